// File: rtl/rv32v_lane_sequencer.sv
// Vector element sequencer: issues one decoded instruction as two-lane beats
// carrying element offsets, mask bits and write enables toward execute.
module rv32v_lane_sequencer #(
  parameter int VLMAX    = 128,
  parameter int OFFSET_W = $clog2(VLMAX)
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                start,
  input  logic [31:0]         vl,
  input  logic                mask_en,
  input  logic [VLMAX-1:0]    mask_word,
  input  logic                stall,
  input  logic                flush,
  output logic                busy,
  output logic                beat_valid,
  output logic [OFFSET_W-1:0] woffset0,
  output logic [OFFSET_W-1:0] woffset1,
  output logic                mask0,
  output logic                mask1,
  output logic                wen0,
  output logic                wen1,
  output logic                last_beat,
  output logic                done
);

  localparam int CW = OFFSET_W + 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      vl_q, vl_d;
  logic [VLMAX-1:0]   mask_q, mask_d;
  logic               done_q, done_d;

  logic               run;
  logic [OFFSET_W-1:0] off0, off1;
  logic               m0, m1, lb;
  logic [CW-1:0]      vl_clamp;

  assign run  = (state_q == RUN);
  assign off0 = count_q[OFFSET_W-1:0];
  // count is always even, so lane 1 is just the odd neighbour
  assign off1 = {count_q[OFFSET_W-1:1], 1'b1};
  assign m0   = mask_q[off0];
  assign m1   = mask_q[off1];
  assign lb   = (count_q + CW'(2)) >= vl_q;

  assign vl_clamp = (vl > 32'(VLMAX)) ? CW'(VLMAX) : vl[CW-1:0];

  assign busy       = run;
  assign beat_valid = run;
  assign woffset0   = run ? off0 : '0;
  assign woffset1   = run ? off1 : '0;
  assign mask0      = run & m0;
  assign mask1      = run & m1;
  assign wen0       = run & m0 & (count_q < vl_q);
  assign wen1       = run & m1 & ((count_q + CW'(1)) < vl_q);
  assign last_beat  = run & lb;
  assign done       = done_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    vl_d    = vl_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    if (flush) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            vl_d    = vl_clamp;
            mask_d  = mask_en ? mask_word : '1;
            count_d = '0;
            if (vl_clamp != '0) state_d = RUN;
            else                done_d  = 1'b1;
          end
        end
        RUN: begin
          if (!stall) begin
            count_d = count_q + CW'(2);
            if (lb) begin
              state_d = IDLE;
              count_d = '0;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      count_q <= '0;
      vl_q    <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      vl_q    <= vl_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
    end
  end

endmodule
